maze_button_conditioner: RTL and testbench

//  Input stage directly upstream of the maze core. Conditions the four raw, bouncy,

---
 rtl/maze_button_conditioner.sv | 203 ++++++++++++++++++++
 tb/tb_maze_button_conditioner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_button_conditioner.sv
// -----------------------------------------------------------------------------
// maze_button_conditioner
//
// Purpose:
//   Front end for the maze core's direction inputs. It turns four raw, bouncy,
//   asynchronous push buttons into clean levels, so that the core sees exactly
//   one rising edge of "any button held" for each physical press.
//
//   Optional feature: define MAZE_AUTOREPEAT_EN to enable keyboard-style
//   auto-repeat. A single button held for REPEAT_DELAY cycles makes dir_out
//   drop to 0 for REPEAT_GAP cycles. After that, it is asserted for
//   REPEAT_PERIOD cycles between further gaps. When the macro is undefined,
//   dir_out simply follows the debounced state.
//
// Ports:
//   clk            in   1  clock, all state on rising edge
//   rst            in   1  asynchronous reset, active-high
//   btn_raw        in   4  raw buttons {right,left,down,up}, async, active-high
//   dir_out        out  4  conditioned directions, same bit order (registered)
//   any_held       out  1  OR of debounced state, unaffected by repeat gaps
//   repeat_active  out  1  high while auto-repeat is in GAP or REPEAT
// -----------------------------------------------------------------------------
module maze_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 4096,
  parameter int REPEAT_PERIOD   = 1024,
  parameter int REPEAT_GAP      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] dir_out,
  output logic       any_held,
  output logic       repeat_active
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_GAP < 3 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("maze_button_conditioner: parameter out of range");
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer, then per-bit debounce counters
  // ---------------------------------------------------------------------------
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  // The counter counts consecutive synced samples that disagree with the
  // debounced bit. Any agreeing sample restarts it, so a bounce shorter than
  // DEBOUNCE_CYCLES never gets through. The toggle fires on the sample that
  // would bring the count to DEBOUNCE_CYCLES. That means the counter never
  // holds that value, and so it cannot wrap.
  always_comb begin
    deb_d = deb_q;
    for (int b = 0; b < 4; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[b] = ~deb_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  // Next values of the output registers
  logic [3:0] dir_d;
  logic       active_d;

`ifdef MAZE_AUTOREPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat FSM
  // ---------------------------------------------------------------------------
  localparam int TMAX_A = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMAX   = (TMAX_A > REPEAT_GAP) ? TMAX_A : REPEAT_GAP;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_GAP, S_REPEAT} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state. The FSM looks at the debounced value being loaded this cycle
  // (deb_d). As a result, state and dir_out move on the same edge as the
  // debounced bits, and no stale cycle appears in between.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (deb_d == 4'b0000) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else if (deb_d != deb_q) begin
      // A newly pressed or changed combination restarts the hold timing.
      // This wins over any timer expiry in the same cycle.
      state_d = S_PRESSED;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_PRESSED;
          timer_d = '0;
        end
        S_PRESSED: begin
          // The timer saturates at the delay, so a multi-button hold parks
          // here and never repeats.
          if (timer_q == TW'(REPEAT_DELAY - 1)) begin
            if ($onehot(deb_q)) begin
              state_d = S_GAP;
              timer_d = '0;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_GAP: begin
          if (timer_q == TW'(REPEAT_GAP - 1)) begin
            state_d = S_REPEAT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (timer_q == TW'(REPEAT_PERIOD - 1)) begin
            state_d = S_GAP;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs, taken from the next state so they can be registered glitch-free
  always_comb begin
    dir_d    = (state_d == S_GAP) ? 4'b0000 : deb_d;
    active_d = (state_d == S_GAP) || (state_d == S_REPEAT);
  end
`else
  always_comb begin
    dir_d    = deb_d;
    active_d = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output registers: no combinational path from btn_raw to any output
  // ---------------------------------------------------------------------------
  logic [3:0] dir_q;
  logic       held_q;
  logic       active_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q    <= '0;
      held_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      held_q   <= |deb_d;
      active_q <= active_d;
    end
  end

  assign dir_out       = dir_q;
  assign any_held      = held_q;
  assign repeat_active = active_q;

endmodule

// File: tb/tb_maze_button_conditioner.sv
module tb_maze_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 10;
  localparam int RG  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] dir_out;
  logic       any_held;
  logic       repeat_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maze_button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_GAP     (RG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .dir_out      (dir_out),
    .any_held     (any_held),
    .repeat_active(repeat_active)
  );

  // ---------------------------------------------------------------------------
  // Reference model: delay line for the synchronizer and a run-length per bit
  // for debounce. Auto-repeat is a closed-form function of how long the
  // current debounced value has been held.
  // ---------------------------------------------------------------------------
  logic [3:0] m_s1, m_s2, m_deb;
  int         m_run [4];
  int         m_cyc;
  int         m_hold_start;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    m_cyc = 0;
    m_hold_start = 0;
  endtask

  task automatic model_step();
    logic [3:0] prev;
    prev = m_deb;
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] != m_deb[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == DEB) begin
          m_deb[b] = ~m_deb[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
    m_cyc = m_cyc + 1;
    if (m_deb != prev) m_hold_start = m_cyc;
  endtask

  function automatic logic [3:0] m_dir();
    int e;
    int k;
    e = m_cyc - m_hold_start;
`ifdef MAZE_AUTOREPEAT_EN
    if (m_deb == 4'b0000 || !$onehot(m_deb) || e < RD) return m_deb;
    k = (e - RD) % (RG + RP);
    return (k < RG) ? 4'b0000 : m_deb;
`else
    k = e;
    return m_deb;
`endif
  endfunction

  function automatic logic m_active();
`ifdef MAZE_AUTOREPEAT_EN
    return (m_deb != 4'b0000) && $onehot(m_deb) && ((m_cyc - m_hold_start) >= RD);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] d, input logic h, input logic a);
    chk({nm, "_dir"}, dir_out, d);
    chk({nm, "_held"}, {3'b000, any_held}, {3'b000, h});
    chk({nm, "_ract"}, {3'b000, repeat_active}, {3'b000, a});
  endtask

  // One clock edge, with the model stepped; returns on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_raw = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] btn;
    int         n;
    logic [3:0] dir;
    logic       held;
    logic       act;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    logic [3:0] e_dir;
    logic       e_act;
    logic [3:0] tgt;
    logic [3:0] val;
    int         len;

    // btn held for n edges, then the outputs are checked
    vecs[0]  = '{4'b0001,  5, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001,  1, 4'b0001, 1'b1, 1'b0};
    vecs[2]  = '{4'b0001, 10, 4'b0001, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000,  5, 4'b0001, 1'b1, 1'b0};
    vecs[4]  = '{4'b0000,  1, 4'b0000, 1'b0, 1'b0};
    vecs[5]  = '{4'b0100,  3, 4'b0000, 1'b0, 1'b0};
    vecs[6]  = '{4'b0000,  1, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100,  2, 4'b0000, 1'b0, 1'b0};
    vecs[8]  = '{4'b0000,  8, 4'b0000, 1'b0, 1'b0};
    vecs[9]  = '{4'b0100,  4, 4'b0000, 1'b0, 1'b0};
    vecs[10] = '{4'b0000,  2, 4'b0100, 1'b1, 1'b0};
    vecs[11] = '{4'b0000,  3, 4'b0100, 1'b1, 1'b0};
    vecs[12] = '{4'b0000,  1, 4'b0000, 1'b0, 1'b0};
    vecs[13] = '{4'b1010,  6, 4'b1010, 1'b1, 1'b0};
    vecs[14] = '{4'b1010, 40, 4'b1010, 1'b1, 1'b0};
    vecs[15] = '{4'b0000,  6, 4'b0000, 1'b0, 1'b0};
    vecs[16] = '{4'b1111,  6, 4'b1111, 1'b1, 1'b0};
    vecs[17] = '{4'b0111,  5, 4'b1111, 1'b1, 1'b0};
    vecs[18] = '{4'b0111,  1, 4'b0111, 1'b1, 1'b0};
    vecs[19] = '{4'b0000,  6, 4'b0000, 1'b0, 1'b0};

    // Reset state
    do_reset();
    chk_all("reset", 4'b0000, 1'b0, 1'b0);

    // Table-driven debounce vectors
    for (int i = 0; i < NV; i++) begin
      btn_raw = vecs[i].btn;
      repeat (vecs[i].n) tick();
      chk_all($sformatf("vec%0d", i), vecs[i].dir, vecs[i].held, vecs[i].act);
    end

    // Asynchronous reset during a hold, then recovery with the button still down
    do_reset();
    btn_raw = 4'b0001;
    repeat (10) tick();
    chk("t1_pre_dir", dir_out, 4'b0001);
    #1 rst = 1'b1;
    #1 chk_all("t1_async", 4'b0000, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) tick();
    chk_all("t1_rel5", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_all("t1_rel6", 4'b0001, 1'b1, 1'b0);

    // Single button held: repeat timeline, checked every cycle
    do_reset();
    btn_raw = 4'b0010;
    for (int c = 1; c <= 60; c++) begin
      tick();
`ifdef MAZE_AUTOREPEAT_EN
      if (c < 6)       e_dir = 4'b0000;
      else if (c < 26) e_dir = 4'b0010;
      else if (c < 30) e_dir = 4'b0000;
      else if (c < 40) e_dir = 4'b0010;
      else if (c < 44) e_dir = 4'b0000;
      else if (c < 54) e_dir = 4'b0010;
      else if (c < 58) e_dir = 4'b0000;
      else             e_dir = 4'b0010;
      e_act = (c >= 26);
`else
      e_dir = (c < 6) ? 4'b0000 : 4'b0010;
      e_act = 1'b0;
`endif
      chk_all($sformatf("t5_c%0d", c), e_dir, (c >= 6), e_act);
    end

    // Second button added while repeating: back to a steady multi-button hold
    do_reset();
    btn_raw = 4'b0010;
    repeat (32) tick();
    btn_raw = 4'b1010;
    repeat (5) tick();
`ifdef MAZE_AUTOREPEAT_EN
    chk_all("t6_c37", 4'b0010, 1'b1, 1'b1);
`else
    chk_all("t6_c37", 4'b0010, 1'b1, 1'b0);
`endif
    for (int c = 38; c <= 90; c++) begin
      tick();
      chk_all($sformatf("t6_c%0d", c), 4'b1010, 1'b1, 1'b0);
    end

    // Randomized presses with bounce, compared against the model every cycle
    do_reset();
    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 9) < 6) tgt = 4'b0001 << $urandom_range(0, 3);
      else                          tgt = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 60);
      for (int j = 0; j < len; j++) begin
        val = tgt;
        if (j < 6 && $urandom_range(0, 3) == 0) val = tgt ^ (4'b0001 << $urandom_range(0, 3));
        btn_raw = val;
        tick();
        chk_all($sformatf("rnd_p%0d_j%0d", p, j), m_dir(), (m_deb != 4'b0000), m_active());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
